// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and types for the MAC accumulate stage
//
// Purpose: default widths, the accumulate FSM state type and the saturation limits.

package mac_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2
  } state_e;

endpackage

// File: rtl/prefix_add_half.sv
// rtl/prefix_add_half.sv - W-bit Kogge-Stone parallel-prefix adder with carry in/out
//
// Purpose: one half of the split accumulate adder.
// Ports:
//   a, b  in  W  addends
//   cin   in  1  carry into bit 0
//   sum   out W  a + b + cin (low W bits)
//   cout  out 1  carry out of bit W-1

module prefix_add_half #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LVL = $clog2(W);

  logic [LVL:0][W-1:0] g_lvl;
  logic [LVL:0][W-1:0] p_lvl;
  logic [W-1:0]        carry;
  logic                p_tail_unused;

  // cin is folded into bit 0's generate so every group prefix already includes it.
  assign p_lvl[0] = a ^ b;
  assign g_lvl[0] = (a & b) | {{(W-1){1'b0}}, p_lvl[0][0] & cin};

  for (genvar l = 1; l <= LVL; l++) begin : g_level
    localparam int DIST = 1 << (l - 1);
    for (genvar i = 0; i < W; i++) begin : g_cell
      if (i >= DIST) begin : g_black
        assign g_lvl[l][i] = g_lvl[l-1][i] | (p_lvl[l-1][i] & g_lvl[l-1][i-DIST]);
        assign p_lvl[l][i] = p_lvl[l-1][i] & p_lvl[l-1][i-DIST];
      end else begin : g_buf
        assign g_lvl[l][i] = g_lvl[l-1][i];
        assign p_lvl[l][i] = p_lvl[l-1][i];
      end
    end
  end

  // Group propagates whose span already reaches bit 0 carry no further information.
  assign p_tail_unused = ^p_lvl;

  assign carry = {g_lvl[LVL][W-2:0], cin};
  assign sum   = p_lvl[0] ^ carry;
  assign cout  = g_lvl[LVL][W-1];

endmodule

// File: rtl/prefix_accumulator.sv
// rtl/prefix_accumulator.sv - two-stage split prefix-adder accumulator for the MAC product path
//
// Purpose: adds each signed product into a signed accumulator, low half in S1,
// high half plus overflow/saturation in S2; one transaction in flight.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       product available
//   in_ready   out  1       high only when idle
//   in_prod    in   PROD_W  signed product
//   in_clear   in   1       start a new sum with this product
//   out_valid  out  1       one-cycle pulse when acc_out updates
//   acc_out    out  ACC_W   signed accumulator
//   ovf        out  1       sticky overflow, cleared by an accepted clear

module prefix_accumulator #(
  parameter int PROD_W   = mac_pkg::PROD_W,
  parameter int ACC_W    = mac_pkg::ACC_W,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_clear,
  output logic              out_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  import mac_pkg::*;

  localparam int L = ACC_W / 2;
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] a_q, a_d, b_q, b_d;
  logic [L-1:0]     lo_q, lo_d;
  logic             c_lo_q, c_lo_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [L-1:0]     lo_sum, hi_sum;
  logic             lo_cout, hi_cout_unused;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;

  prefix_add_half #(.W(L)) u_lo (
    .a    (a_q[L-1:0]),
    .b    (b_q[L-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // Operand registers hold through S2, so the high half reads them directly.
  prefix_add_half #(.W(L)) u_hi (
    .a    (a_q[ACC_W-1:L]),
    .b    (b_q[ACC_W-1:L]),
    .cin  (c_lo_q),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  assign sum     = {hi_sum, lo_q};
  assign sum_ovf = (a_q[ACC_W-1] == b_q[ACC_W-1]) && (sum[ACC_W-1] != a_q[ACC_W-1]);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    lo_d        = lo_q;
    c_lo_d      = c_lo_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_clear ? '0 : acc_q;
          b_d     = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
          state_d = S1;
          if (in_clear) ovf_d = 1'b0;
        end
      end
      S1: begin
        lo_d    = lo_sum;
        c_lo_d  = lo_cout;
        state_d = S2;
      end
      S2: begin
        if (sum_ovf && (SATURATE != 0)) acc_d = a_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
        else                            acc_d = sum;
        if (sum_ovf) ovf_d = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      lo_q        <= '0;
      c_lo_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lo_q        <= lo_d;
      c_lo_q      <= c_lo_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prefix_accumulator.sv
// tb/tb_prefix_accumulator.sv - self-checking bench for prefix_accumulator (saturating and wrapping)

module tb_prefix_accumulator;

  localparam longint MAXV = 64'sd549755813887;
  localparam longint MINV = -64'sd549755813888;
  localparam longint SPAN = 64'sd1099511627776;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_clear;
  logic        rdy_s, rdy_w, ov_s, ov_w, ovf_s, ovf_w;
  logic [39:0] acc_s, acc_w;

  int n_pass  = 0;
  int n_total = 0;

  longint m_sat, m_wrap;
  bit     mo_sat, mo_wrap;

  prefix_accumulator #(.PROD_W(32), .ACC_W(40), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_prod(in_prod),
    .in_clear(in_clear), .out_valid(ov_s), .acc_out(acc_s), .ovf(ovf_s)
  );

  prefix_accumulator #(.PROD_W(32), .ACC_W(40), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w), .in_prod(in_prod),
    .in_clear(in_clear), .out_valid(ov_w), .acc_out(acc_w), .ovf(ovf_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_step(input longint acc, input logic [31:0] prod, input bit clr,
                            input bit sat, input bit ov_in, output longint acc_o, output bit ov_o);
    logic signed [31:0] sp;
    longint a, s;
    sp    = prod;
    a     = clr ? 64'sd0 : acc;
    s     = a + longint'(sp);
    ov_o  = clr ? 1'b0 : ov_in;
    acc_o = s;
    if (s > MAXV || s < MINV) begin
      ov_o = 1'b1;
      if (sat) acc_o = (a < 0) ? MINV : MAXV;
      else     acc_o = (s > MAXV) ? s - SPAN : s + SPAN;
    end
  endtask

  function automatic logic [39:0] to40(input longint v);
    logic [63:0] t;
    t = v;
    return t[39:0];
  endfunction

  // Entered at a negedge with the DUTs idle; leaves at the negedge of the out_valid cycle.
  task automatic txn(input logic [31:0] prod, input bit clr);
    logic [39:0] old_s, old_w;
    old_s = to40(m_sat);
    old_w = to40(m_wrap);
    chk("ready_before_s", rdy_s, 1);
    chk("ready_before_w", rdy_w, 1);
    in_valid = 1'b1;
    in_prod  = prod;
    in_clear = clr;
    @(negedge clk);
    in_valid = 1'b0;
    in_prod  = $urandom;
    in_clear = $urandom_range(0, 1);
    chk("busy_s1_s", rdy_s, 0);
    chk("busy_s1_w", rdy_w, 0);
    chk("ov_s1", {ov_s, ov_w}, 0);
    chk("hold_s1_s", acc_s, old_s);
    @(negedge clk);
    chk("ov_s2", {ov_s, ov_w}, 0);
    chk("hold_s2_s", acc_s, old_s);
    chk("hold_s2_w", acc_w, old_w);
    model_step(m_sat, prod, clr, 1'b1, mo_sat, m_sat, mo_sat);
    model_step(m_wrap, prod, clr, 1'b0, mo_wrap, m_wrap, mo_wrap);
    @(negedge clk);
    chk("out_valid_s", ov_s, 1);
    chk("out_valid_w", ov_w, 1);
    chk("acc_s", acc_s, to40(m_sat));
    chk("acc_w", acc_w, to40(m_wrap));
    chk("ovf_s", ovf_s, mo_sat);
    chk("ovf_w", ovf_w, mo_wrap);
    chk("ready_after", {rdy_s, rdy_w}, 2'b11);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_prod  = 32'd123;
    in_clear = 1'b0;
    m_sat = 0; m_wrap = 0; mo_sat = 0; mo_wrap = 0;
    repeat (3) @(negedge clk);
    chk("rst_acc", {acc_s, acc_w}, 80'd0);
    chk("rst_ovf", {ovf_s, ovf_w}, 0);
    chk("rst_out_valid", {ov_s, ov_w}, 0);
    chk("rst_ready", {rdy_s, rdy_w}, 2'b11);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Basic sequence, including back-to-back accept in the out_valid cycle.
    txn(32'd5, 1'b1);
    chk("basic_5", acc_s, 40'd5);
    txn(-32'sd3, 1'b0);
    chk("basic_2", acc_s, 40'd2);
    txn(32'd100, 1'b0);
    chk("basic_102", acc_s, 40'd102);
    @(negedge clk);

    // Carry across the half boundary.
    txn(32'h000F_FFFF, 1'b1);
    txn(32'd1, 1'b0);
    chk("carry_half", acc_w, 40'h00_0010_0000);

    // Positive saturation / wrap.
    txn(32'h7FFF_FFFF, 1'b1);
    for (int i = 1; i < 256; i++) txn(32'h7FFF_FFFF, 1'b0);
    chk("near_max", acc_s, 40'h7F_FFFF_FF00);
    chk("near_max_ovf", ovf_s, 0);
    txn(32'h7FFF_FFFF, 1'b0);
    chk("sat_max", acc_s, 40'h7F_FFFF_FFFF);
    chk("sat_max_ovf", ovf_s, 1);
    txn(32'd1, 1'b1);
    chk("clear_after_sat", acc_s, 40'd1);
    chk("clear_ovf", ovf_s, 0);

    // Reach the most negative value exactly, then step below it.
    txn(32'h8000_0000, 1'b1);
    for (int i = 1; i < 256; i++) txn(32'h8000_0000, 1'b0);
    chk("at_min", acc_w, 40'h80_0000_0000);
    chk("at_min_ovf", ovf_w, 0);
    txn(32'hFFFF_FFFF, 1'b0);
    chk("wrap_neg", acc_w, 40'h7F_FFFF_FFFF);
    chk("wrap_neg_ovf", ovf_w, 1);
    chk("sat_neg", acc_s, 40'h80_0000_0000);

    // Randomized traffic with occasional clears and idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
      txn(p, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    // Reset during S1 aborts the transaction.
    in_valid = 1'b1;
    in_prod  = 32'd7;
    in_clear = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("abort_acc", {acc_s, acc_w}, 80'd0);
    chk("abort_ovf", {ovf_s, ovf_w}, 0);
    chk("abort_ready", {rdy_s, rdy_w}, 2'b11);
    @(negedge clk);
    chk("abort_no_valid", {ov_s, ov_w}, 0);
    rst_n = 1'b1;
    m_sat = 0; m_wrap = 0; mo_sat = 0; mo_wrap = 0;
    txn(32'd9, 1'b0);
    chk("after_abort", acc_s, 40'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
